// File: rtl/mem_ctrl_pkg.sv
// Shared types and width helpers for the memory write sequencer.
package mem_ctrl_pkg;

  typedef enum logic {INIT, RUN} mem_seq_state_t;

  // Address width for a memory of the given depth (at least one bit).
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Encoded requester-id width (at least one bit).
  function automatic int unsigned id_width(input int unsigned n_req);
    return (n_req < 2) ? 1 : $clog2(n_req);
  endfunction

endpackage

// File: rtl/mem_write_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
module rr_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) (
  input  logic [N_REQ-1:0]              req,
  input  logic [id_width(N_REQ)-1:0]    ptr,
  input  logic                          en,
  output logic [N_REQ-1:0]              gnt,
  output logic [id_width(N_REQ)-1:0]    gnt_id
);

  localparam int unsigned GW = id_width(N_REQ);

  logic              found;
  int unsigned       sum;
  logic [GW-1:0]     idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    sum    = 0;
    idx    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      sum = 32'(ptr) + i;
      idx = GW'(sum % N_REQ);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_write_sequencer.sv
// Owns the memory write port: init sweep after reset, then round-robin
// sharing among requesters with registered memory-side outputs.
module mem_write_sequencer
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned       WIDTH      = 32,
  parameter int unsigned       N          = 4,
  parameter int unsigned       N_REQ      = 3,
  parameter logic [WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  init_start,
  input  logic [N_REQ-1:0]                      req_valid,
  input  logic [N_REQ-1:0][addr_width(N)-1:0]   req_addr,
  input  logic [N_REQ-1:0][WIDTH-1:0]           req_data,
  output logic [N_REQ-1:0]                      req_ready,
  output logic                                  mem_write_en,
  output logic [addr_width(N)-1:0]              mem_write_addr,
  output logic [WIDTH-1:0]                      mem_data_in,
  output logic [id_width(N_REQ)-1:0]            mem_grant_id,
  output logic                                  init_done
);

  localparam int unsigned AW = addr_width(N);
  localparam int unsigned GW = id_width(N_REQ);
  localparam int unsigned CW = AW + 1;

  mem_seq_state_t  state;
  logic [CW-1:0]   init_cnt;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   gnt_id;
  logic            arb_en;
  logic            handshake;

  // Re-init request blocks granting in the same cycle.
  assign arb_en    = (state == RUN) && !init_start;
  assign handshake = |(req_valid & req_ready);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .en     (arb_en),
    .gnt    (req_ready),
    .gnt_id (gnt_id)
  );

  // Sweep counter runs to N; the extra step hands over to RUN without a write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= INIT;
      init_cnt       <= '0;
      rr_ptr         <= '0;
      mem_write_en   <= 1'b0;
      mem_write_addr <= '0;
      mem_data_in    <= '0;
      mem_grant_id   <= '0;
      init_done      <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          mem_grant_id <= '0;
          if (init_cnt == CW'(N)) begin
            mem_write_en <= 1'b0;
            init_cnt     <= '0;
            init_done    <= 1'b1;
            state        <= RUN;
          end else begin
            mem_write_en   <= 1'b1;
            mem_write_addr <= init_cnt[AW-1:0];
            mem_data_in    <= INIT_VALUE;
            init_cnt       <= init_cnt + CW'(1);
          end
        end
        RUN: begin
          if (init_start) begin
            mem_write_en <= 1'b0;
            init_done    <= 1'b0;
            init_cnt     <= '0;
            rr_ptr       <= '0;
            state        <= INIT;
          end else if (handshake) begin
            mem_write_en   <= 1'b1;
            mem_write_addr <= req_addr[gnt_id];
            mem_data_in    <= req_data[gnt_id];
            mem_grant_id   <= gnt_id;
            rr_ptr         <= (gnt_id == GW'(N_REQ - 1)) ? '0 : gnt_id + GW'(1);
          end else begin
            mem_write_en <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
